// File: rtl/spram_arb_pkg.sv
// Shared types and defaults for the two-requester single-port RAM arbiter.
//   owner_t    : who currently owns the RAM port (nobody, A or B)
//   ID_A/ID_B  : one-bit requester ids carried with read tags
//   tie_winner : round-robin pick used whenever ownership is re-decided
package spram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    localparam int DEF_AW        = 4;
    localparam int DEF_DW        = 8;
    localparam int DEF_RD_LAT    = 1;
    localparam int DEF_MAX_BURST = 4;

    // Round-robin choice: a lone requester wins, a tie goes to whoever was not granted last.
    function automatic owner_t tie_winner(input logic a_valid, input logic b_valid,
                                          input logic last_gnt);
        owner_t w;
        if (a_valid && b_valid) begin
            w = (last_gnt == ID_A) ? OWN_B : OWN_A;
        end else if (a_valid) begin
            w = OWN_A;
        end else if (b_valid) begin
            w = OWN_B;
        end else begin
            w = OWN_IDLE;
        end
        return w;
    endfunction

endpackage

// File: rtl/spram_rsp_tracker.sv
// Read-response tracker: carries a (read, requester id) tag alongside each issued read
// and, when the RAM data for that read is due, captures ram_dout into the issuer's
// response register.
//   clk, rst_n        : clock, synchronous active-low reset
//   issue_rd, issue_id: a read was accepted this cycle, and by whom
//   ram_dout          : RAM read data
//   a_rsp_* / b_rsp_* : per-requester one-cycle valid pulse and held data
module spram_rsp_tracker
    import spram_arb_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue_rd,
    input  logic          issue_id,
    input  logic [DW-1:0] ram_dout,
    output logic          a_rsp_valid,
    output logic [DW-1:0] a_rsp_data,
    output logic          b_rsp_valid,
    output logic [DW-1:0] b_rsp_data
);

    // Stage k holds the tag of the read accepted k cycles ago; the last stage lines up
    // with the cycle in which ram_dout carries that read's data.
    localparam int DEPTH = RD_LAT + 1;

    logic [DEPTH-1:0] vld_r;
    logic [DEPTH-1:0] id_r;
    logic             due_a_s;
    logic             due_b_s;

    assign due_a_s = vld_r[DEPTH-1] && (id_r[DEPTH-1] == ID_A);
    assign due_b_s = vld_r[DEPTH-1] && (id_r[DEPTH-1] == ID_B);

    // Tag shift register; reset drops every read still in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_r <= '0;
            id_r  <= '0;
        end else begin
            vld_r <= {vld_r[DEPTH-2:0], issue_rd};
            id_r  <= {id_r[DEPTH-2:0], issue_id};
        end
    end

    // Response demux: pulse valid for the issuer and capture data, otherwise hold data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_rsp_valid <= 1'b0;
            a_rsp_data  <= '0;
            b_rsp_valid <= 1'b0;
            b_rsp_data  <= '0;
        end else begin
            a_rsp_valid <= due_a_s;
            b_rsp_valid <= due_b_s;
            if (due_a_s) begin
                a_rsp_data <= ram_dout;
            end else begin
                a_rsp_data <= a_rsp_data;
            end
            if (due_b_s) begin
                b_rsp_data <= ram_dout;
            end else begin
                b_rsp_data <= b_rsp_data;
            end
        end
    end

endmodule

// File: rtl/spram_arbiter.sv
// Two-requester arbiter/sequencer for one single-port RAM (sync write, registered read).
// Grants the RAM port round-robin with an optional bounded burst lock, registers the
// accepted command onto the RAM port, and routes read data back to the issuer.
//   clk, rst_n              : clock, synchronous active-low reset
//   a_valid/a_we/a_lock/a_addr/a_wdata, a_ready : requester A command handshake
//   a_rsp_valid/a_rsp_data  : requester A read response
//   b_*                     : identical set for requester B
//   ram_we/ram_addr/ram_din : registered RAM port, ram_dout : RAM read data
module spram_arbiter
    import spram_arb_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int RD_LAT    = DEF_RD_LAT,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_valid,
    input  logic          a_we,
    input  logic          a_lock,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ready,
    output logic          a_rsp_valid,
    output logic [DW-1:0] a_rsp_data,
    input  logic          b_valid,
    input  logic          b_we,
    input  logic          b_lock,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ready,
    output logic          b_rsp_valid,
    output logic [DW-1:0] b_rsp_data,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam int            CW      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

    owner_t        state_r;
    owner_t        state_nxt_s;
    logic          last_gnt_r;
    logic [CW-1:0] burst_cnt_r;
    logic [CW-1:0] burst_cnt_nxt_s;
    logic          keep_s;
    logic          issue_rd_s;
    logic          issue_id_s;

    // Owner register: state, burst length and round-robin memory (A wins the first tie).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= OWN_IDLE;
            burst_cnt_r <= '0;
            last_gnt_r  <= ID_B;
        end else begin
            state_r     <= state_nxt_s;
            burst_cnt_r <= burst_cnt_nxt_s;
            if (state_nxt_s == OWN_A) begin
                last_gnt_r <= ID_A;
            end else if (state_nxt_s == OWN_B) begin
                last_gnt_r <= ID_B;
            end else begin
                last_gnt_r <= last_gnt_r;
            end
        end
    end

    // Next owner: a locking owner keeps the port until its burst budget runs out while
    // the other side waits; otherwise fall back to the round-robin tie rule.
    // The next owner is exactly the requester granted this cycle.
    always_comb begin
        state_nxt_s = OWN_IDLE;
        keep_s      = 1'b0;
        case (state_r)
            OWN_A: begin
                if (a_valid && a_lock && ((burst_cnt_r < CNT_MAX) || !b_valid)) begin
                    state_nxt_s = OWN_A;
                    keep_s      = 1'b1;
                end else begin
                    state_nxt_s = tie_winner(a_valid, b_valid, last_gnt_r);
                end
            end
            OWN_B: begin
                if (b_valid && b_lock && ((burst_cnt_r < CNT_MAX) || !a_valid)) begin
                    state_nxt_s = OWN_B;
                    keep_s      = 1'b1;
                end else begin
                    state_nxt_s = tie_winner(a_valid, b_valid, last_gnt_r);
                end
            end
            OWN_IDLE: begin
                state_nxt_s = tie_winner(a_valid, b_valid, last_gnt_r);
            end
            default: begin
                state_nxt_s = tie_winner(a_valid, b_valid, last_gnt_r);
            end
        endcase
    end

    // Burst length: counts locked re-grants (saturating), cleared by any other decision.
    always_comb begin
        burst_cnt_nxt_s = '0;
        if (keep_s && (burst_cnt_r != CNT_MAX)) begin
            burst_cnt_nxt_s = burst_cnt_r + CW'(1);
        end else if (keep_s) begin
            burst_cnt_nxt_s = burst_cnt_r;
        end else begin
            burst_cnt_nxt_s = '0;
        end
    end

    // Grant outputs; held low during reset so no command is accepted then.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (rst_n) begin
            a_ready = (state_nxt_s == OWN_A);
            b_ready = (state_nxt_s == OWN_B);
        end else begin
            a_ready = 1'b0;
            b_ready = 1'b0;
        end
    end

    // RAM port register: write enable is a one-cycle pulse, address/data hold when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else if (a_ready) begin
            ram_we   <= a_we;
            ram_addr <= a_addr;
            ram_din  <= a_wdata;
        end else if (b_ready) begin
            ram_we   <= b_we;
            ram_addr <= b_addr;
            ram_din  <= b_wdata;
        end else begin
            ram_we   <= 1'b0;
            ram_addr <= ram_addr;
            ram_din  <= ram_din;
        end
    end

    assign issue_rd_s = (a_ready && !a_we) || (b_ready && !b_we);
    assign issue_id_s = b_ready ? ID_B : ID_A;

    spram_rsp_tracker #(
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) u_rsp (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_rd    (issue_rd_s),
        .issue_id    (issue_id_s),
        .ram_dout    (ram_dout),
        .a_rsp_valid (a_rsp_valid),
        .a_rsp_data  (a_rsp_data),
        .b_rsp_valid (b_rsp_valid),
        .b_rsp_data  (b_rsp_data)
    );

endmodule

// File: tb/tb_spram_arbiter.sv
// Self-checking bench for spram_arbiter with a behavioural 16x8 single-port RAM
// (sync write, one-cycle registered read).
module tb_spram_arbiter;

    localparam int MAXB = 4;

    logic       clk;
    logic       rst_n;
    logic       a_valid, a_we, a_lock, a_ready, a_rsp_valid;
    logic [3:0] a_addr;
    logic [7:0] a_wdata, a_rsp_data;
    logic       b_valid, b_we, b_lock, b_ready, b_rsp_valid;
    logic [3:0] b_addr;
    logic [7:0] b_wdata, b_rsp_data;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_din, ram_dout;
    logic [7:0] ram_mem [16];

    int n_checks = 0;
    int n_fail   = 0;

    spram_arbiter #(.AW(4), .DW(8), .RD_LAT(1), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ready(a_ready), .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
        .b_valid(b_valid), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ready(b_ready), .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM: read-first, registered output.
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic we, input logic lk,
                         input logic [3:0] ad, input logic [7:0] d);
        a_valid = v; a_we = we; a_lock = lk; a_addr = ad; a_wdata = d;
    endtask

    task automatic set_b(input logic v, input logic we, input logic lk,
                         input logic [3:0] ad, input logic [7:0] d);
        b_valid = v; b_we = we; b_lock = lk; b_addr = ad; b_wdata = d;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        set_a(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        set_b(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_a(1'b1, 1'b0, 1'b0, 4'd5, 8'h12);
        set_b(1'b1, 1'b1, 1'b0, 4'd6, 8'h34);
        #1;
        n_checks++;
        if ({a_ready, b_ready} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ready: got %b, want 00", {a_ready, b_ready});
        end
        step(); step();
        n_checks++;
        if ({ram_we, ram_addr, ram_din, a_rsp_valid, a_rsp_data, b_rsp_valid, b_rsp_data} !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: we=%b addr=%h din=%h arv=%b ard=%h brv=%b brd=%h, want all 0",
                     ram_we, ram_addr, ram_din, a_rsp_valid, a_rsp_data, b_rsp_valid, b_rsp_data);
        end
        do_reset(1);
    endtask

    task automatic test_write_read();
        set_a(1'b1, 1'b1, 1'b0, 4'd1, 8'hA5);
        #1;
        n_checks++;
        if ({a_ready, b_ready} !== 2'b10) begin
            n_fail++; $display("FAIL wr_grant: got %b, want 10", {a_ready, b_ready});
        end
        step();
        n_checks++;
        if ({ram_we, ram_addr, ram_din} !== {1'b1, 4'd1, 8'hA5}) begin
            n_fail++; $display("FAIL wr_issue: we=%b addr=%h din=%h, want 1 1 a5", ram_we, ram_addr, ram_din);
        end
        set_a(1'b1, 1'b0, 1'b0, 4'd1, 8'h00);
        #1;
        n_checks++;
        if (a_ready !== 1'b1) begin
            n_fail++; $display("FAIL rd_grant: a_ready=%b, want 1", a_ready);
        end
        step();
        n_checks++;
        if ({ram_we, ram_addr} !== {1'b0, 4'd1}) begin
            n_fail++; $display("FAIL we_pulse: we=%b addr=%h, want 0 1", ram_we, ram_addr);
        end
        set_a(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        step();
        n_checks++;
        if ({a_rsp_valid, b_rsp_valid} !== 2'b00) begin
            n_fail++; $display("FAIL rd_early: rsp_valid a/b=%b, want 00", {a_rsp_valid, b_rsp_valid});
        end
        step();
        n_checks++;
        if ({a_rsp_valid, a_rsp_data, b_rsp_valid} !== {1'b1, 8'hA5, 1'b0}) begin
            n_fail++; $display("FAIL rd_rsp: arv=%b ard=%h brv=%b, want 1 a5 0", a_rsp_valid, a_rsp_data, b_rsp_valid);
        end
        step();
        n_checks++;
        if ({a_rsp_valid, a_rsp_data} !== {1'b0, 8'hA5}) begin
            n_fail++; $display("FAIL rsp_hold: arv=%b ard=%h, want 0 a5", a_rsp_valid, a_rsp_data);
        end
    endtask

    task automatic test_alternate();
        int ia = 0;
        int ib = 0;
        int q_id [10];
        int q_ad [10];
        logic exp_a;
        for (int i = 0; i < 8; i++) begin
            set_a(1'b1, 1'b1, 1'b0, 4'(i), 8'(8'h10 + i));
            step();
        end
        do_reset(2);
        for (int k = 0; k < 12; k++) begin
            if (k < 10) begin
                set_a(1'b1, 1'b0, 1'b0, 4'((2 * ia) % 8), 8'h00);
                set_b(1'b1, 1'b0, 1'b0, 4'((2 * ib + 1) % 8), 8'h00);
                #1;
                exp_a = (k % 2 == 0);
                n_checks++;
                if ({a_ready, b_ready} !== {exp_a, !exp_a}) begin
                    n_fail++; $display("FAIL alt_grant[%0d]: got %b, want %b", k, {a_ready, b_ready}, {exp_a, !exp_a});
                end
                q_id[k] = exp_a ? 1 : 2;
                q_ad[k] = exp_a ? int'(a_addr) : int'(b_addr);
                if (a_ready) ia++;
                if (b_ready) ib++;
            end else begin
                set_a(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
                set_b(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
            end
            step();
            if (k >= 2) begin
                n_checks++;
                if (q_id[k-2] == 1) begin
                    if ({a_rsp_valid, b_rsp_valid, a_rsp_data} !== {2'b10, 8'(8'h10 + q_ad[k-2])}) begin
                        n_fail++; $display("FAIL alt_rsp[%0d]: arv=%b brv=%b ard=%h, want 1 0 %h",
                                           k - 2, a_rsp_valid, b_rsp_valid, a_rsp_data, 8'(8'h10 + q_ad[k-2]));
                    end
                end else begin
                    if ({a_rsp_valid, b_rsp_valid, b_rsp_data} !== {2'b01, 8'(8'h10 + q_ad[k-2])}) begin
                        n_fail++; $display("FAIL alt_rsp[%0d]: arv=%b brv=%b brd=%h, want 0 1 %h",
                                           k - 2, a_rsp_valid, b_rsp_valid, b_rsp_data, 8'(8'h10 + q_ad[k-2]));
                    end
                end
            end
        end
    endtask

    task automatic test_burst_lock();
        logic exp_a;
        do_reset(2);
        for (int k = 0; k < 10; k++) begin
            set_a(1'b1, 1'b1, 1'b1, 4'(8 + k % 8), 8'(k));
            set_b(1'b1, 1'b1, 1'b0, 4'd15, 8'(8'h80 + k));
            #1;
            exp_a = (k % 5 != 4);
            n_checks++;
            if ({a_ready, b_ready} !== {exp_a, !exp_a}) begin
                n_fail++; $display("FAIL burst_grant[%0d]: got %b, want %b", k, {a_ready, b_ready}, {exp_a, !exp_a});
            end
            step();
        end
        n_checks++;
        if (ram_we !== 1'b1) begin
            n_fail++; $display("FAIL burst_we: ram_we=%b, want 1", ram_we);
        end
    endtask

    task automatic test_lock_no_b();
        set_b(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        for (int k = 0; k < 10; k++) begin
            set_a(1'b1, 1'b1, 1'b1, 4'(8 + k % 8), 8'(8'h40 + k));
            #1;
            n_checks++;
            if ({a_ready, b_ready} !== 2'b10) begin
                n_fail++; $display("FAIL lock_solo[%0d]: got %b, want 10", k, {a_ready, b_ready});
            end
            step();
        end
        set_a(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        step();
    endtask

    task automatic test_raw();
        set_b(1'b1, 1'b1, 1'b0, 4'd3, 8'h3C);
        #1;
        n_checks++;
        if (b_ready !== 1'b1) begin
            n_fail++; $display("FAIL raw_bgrant: b_ready=%b, want 1", b_ready);
        end
        step();
        set_b(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        set_a(1'b1, 1'b0, 1'b0, 4'd3, 8'h00);
        #1;
        n_checks++;
        if (a_ready !== 1'b1) begin
            n_fail++; $display("FAIL raw_agrant: a_ready=%b, want 1", a_ready);
        end
        step();
        set_a(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        step(); step();
        n_checks++;
        if ({a_rsp_valid, a_rsp_data, b_rsp_valid} !== {1'b1, 8'h3C, 1'b0}) begin
            n_fail++; $display("FAIL raw_data: arv=%b ard=%h brv=%b, want 1 3c 0", a_rsp_valid, a_rsp_data, b_rsp_valid);
        end
    endtask

    task automatic test_reset_inflight();
        set_a(1'b1, 1'b0, 1'b0, 4'd1, 8'h00);
        #1;
        n_checks++;
        if (a_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre_grant: a_ready=%b, want 1", a_ready);
        end
        step();
        rst_n = 1'b0;
        set_a(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        set_b(1'b1, 1'b0, 1'b0, 4'd2, 8'h00);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if ({a_ready, b_ready} !== 2'b00) begin
                n_fail++; $display("FAIL rst_ready[%0d]: got %b, want 00", k, {a_ready, b_ready});
            end
            step();
            n_checks++;
            if ({ram_we, ram_addr, ram_din, a_rsp_valid, a_rsp_data, b_rsp_valid, b_rsp_data} !== 31'd0) begin
                n_fail++; $display("FAIL rst_out[%0d]: we=%b addr=%h din=%h arv=%b ard=%h brv=%b brd=%h, want all 0",
                                   k, ram_we, ram_addr, ram_din, a_rsp_valid, a_rsp_data, b_rsp_valid, b_rsp_data);
            end
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({a_ready, b_ready} !== 2'b10) begin
            n_fail++; $display("FAIL rst_first_tie: got %b, want 10", {a_ready, b_ready});
        end
        step();
        set_a(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        set_b(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        step(); step();
        n_checks++;
        if ({a_rsp_valid, a_rsp_data} !== {1'b1, 8'h10}) begin
            n_fail++; $display("FAIL rst_post_rd: arv=%b ard=%h, want 1 10", a_rsp_valid, a_rsp_data);
        end
    endtask

    typedef struct {
        int         due;
        int         id;
        logic       known;
        logic [7:0] data;
    } rsp_t;

    // Reference model: owner (0 none, 1 A, 2 B), last winner, locked re-grant run length.
    task automatic test_random();
        rsp_t       rq [$];
        rsp_t       r;
        logic [7:0] ref_mem [16];
        logic       known [16];
        int         own = 0;
        int         last = 2;
        int         streak = 0;
        int         g;
        bit         keep;
        bit         pend_a = 0;
        bit         pend_b = 0;
        logic       exp_we = 1'b0;
        logic [3:0] exp_addr = 4'd0;
        logic [7:0] exp_din = 8'd0;
        logic [3:0] cad;
        logic       cwe;
        logic [7:0] cd;
        logic       exp_arv, exp_brv, exp_known;
        logic [7:0] exp_d;
        for (int i = 0; i < 16; i++) known[i] = 1'b0;
        do_reset(2);
        for (int cyc = 0; cyc < 303; cyc++) begin
            if (cyc < 300 && !pend_a && $urandom_range(0, 3) != 0) begin
                set_a(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
                pend_a = 1;
            end else if (!pend_a) begin
                a_valid = 1'b0;
            end
            if (cyc < 300 && !pend_b && $urandom_range(0, 3) != 0) begin
                set_b(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
                pend_b = 1;
            end else if (!pend_b) begin
                b_valid = 1'b0;
            end
            #1;
            keep = 0;
            if (own == 1 && a_valid && a_lock && (streak < MAXB - 1 || !b_valid)) begin
                g = 1; keep = 1;
            end else if (own == 2 && b_valid && b_lock && (streak < MAXB - 1 || !a_valid)) begin
                g = 2; keep = 1;
            end else if (a_valid && b_valid) begin
                g = (last == 1) ? 2 : 1;
            end else if (a_valid) begin
                g = 1;
            end else if (b_valid) begin
                g = 2;
            end else begin
                g = 0;
            end
            streak = keep ? ((streak + 1 > MAXB - 1) ? MAXB - 1 : streak + 1) : 0;
            own = g;
            if (g != 0) last = g;
            n_checks++;
            if ({a_ready, b_ready} !== {g == 1, g == 2}) begin
                n_fail++; $display("FAIL rnd_grant[%0d]: got %b, want %b", cyc, {a_ready, b_ready}, {g == 1, g == 2});
            end
            exp_we = 1'b0;
            if (g != 0) begin
                cad = (g == 1) ? a_addr : b_addr;
                cwe = (g == 1) ? a_we : b_we;
                cd  = (g == 1) ? a_wdata : b_wdata;
                exp_addr = cad;
                if (cwe) begin
                    exp_we = 1'b1; exp_din = cd;
                    ref_mem[cad] = cd; known[cad] = 1'b1;
                end else begin
                    rq.push_back('{due: cyc + 2, id: g, known: known[cad], data: ref_mem[cad]});
                end
            end
            if (a_ready) pend_a = 0;
            if (b_ready) pend_b = 0;
            step();
            n_checks++;
            if ({ram_we, ram_addr} !== {exp_we, exp_addr} || (exp_we && ram_din !== exp_din)) begin
                n_fail++; $display("FAIL rnd_port[%0d]: we=%b addr=%h din=%h, want %b %h %h",
                                   cyc, ram_we, ram_addr, ram_din, exp_we, exp_addr, exp_din);
            end
            exp_arv = 1'b0; exp_brv = 1'b0; exp_known = 1'b0; exp_d = 8'd0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                r = rq.pop_front();
                exp_arv = (r.id == 1); exp_brv = (r.id == 2);
                exp_known = r.known; exp_d = r.data;
            end
            n_checks++;
            if ({a_rsp_valid, b_rsp_valid} !== {exp_arv, exp_brv} ||
                (exp_known && exp_arv && a_rsp_data !== exp_d) ||
                (exp_known && exp_brv && b_rsp_data !== exp_d)) begin
                n_fail++; $display("FAIL rnd_rsp[%0d]: arv=%b brv=%b ard=%h brd=%h, want %b %b data %h",
                                   cyc, a_rsp_valid, b_rsp_valid, a_rsp_data, b_rsp_data, exp_arv, exp_brv, exp_d);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_a(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        set_b(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        test_reset();
        test_write_read();
        test_alternate();
        test_burst_lock();
        test_lock_no_b();
        test_raw();
        test_reset_inflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
